// File: rtl/branch_history_predictor.sv
// Fetch-stage branch predictor: instruction-class decode plus a PC-indexed saturating-counter table, with a saturating mispredict counter.
// Prediction is registered (1-cycle latency). No backpressure: one lookup and one update per cycle. Optional macro BHT_BYPASS_EN forwards same-index updates.
module branch_history_predictor #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    input  logic [31:0]     lookup_instr,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [1:0]      pred_kind,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_mispredict,
    output logic [31:0]     mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    // Weakly-not-taken: 01 for 2-bit counters, 0 for 1-bit counters
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_COND = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_JAL  = 2'b11;

    logic [CTR_W-1:0] r_ctr [ENTRIES];
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [1:0]       r_pred_kind;
    logic [31:0]      r_mispredict_count;

    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_update_idx;
    logic [CTR_W-1:0] w_upd_old;
    logic [CTR_W-1:0] w_upd_new;
    logic [CTR_W-1:0] w_lookup_ctr;
    logic [1:0]       w_kind;
    logic             w_taken;

    assign w_lookup_idx = lookup_pc[IDX_W+1:2];
    assign w_update_idx = update_pc[IDX_W+1:2];
    assign w_upd_old    = r_ctr[w_update_idx];

    always_comb begin
        w_upd_new = w_upd_old;
        if (update_taken) begin
            if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + CTR_ONE;
        end else begin
            if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_ONE;
        end
    end

`ifdef BHT_BYPASS_EN
    assign w_lookup_ctr = (update_valid && (w_update_idx == w_lookup_idx)) ? w_upd_new
                                                                           : r_ctr[w_lookup_idx];
`else
    assign w_lookup_ctr = r_ctr[w_lookup_idx];
`endif

    always_comb begin
        w_kind  = KIND_NONE;
        w_taken = 1'b0;
        case (lookup_instr[6:2])
            5'h18: begin
                w_kind  = KIND_COND;
                w_taken = w_lookup_ctr[CTR_W-1];
            end
            5'h19: begin
                w_kind  = KIND_JALR;
                w_taken = 1'b1;
            end
            5'h1b: begin
                w_kind  = KIND_JAL;
                w_taken = 1'b1;
            end
            default: begin
                w_kind  = KIND_NONE;
                w_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
            r_pred_valid       <= 1'b0;
            r_pred_taken       <= 1'b0;
            r_pred_kind        <= KIND_NONE;
            r_mispredict_count <= '0;
        end else begin
            if (update_valid) r_ctr[w_update_idx] <= w_upd_new;

            r_pred_valid <= lookup_valid;
            r_pred_taken <= lookup_valid & w_taken;
            r_pred_kind  <= lookup_valid ? w_kind : KIND_NONE;

            if (update_valid && update_mispredict && (r_mispredict_count != 32'hFFFF_FFFF))
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign pred_valid       = r_pred_valid;
    assign pred_taken       = r_pred_taken;
    assign pred_kind        = r_pred_kind;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed plus randomized bench for branch_history_predictor (ENTRIES=64, CTR_W=2) against an array-based reference model.
module tb_branch_history_predictor;
    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int PC_W    = 32;
    localparam int CMAX    = (1 << CTR_W) - 1;

    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_ADD  = 32'h0000_0033;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            lookup_valid = 1'b0;
    logic [PC_W-1:0] lookup_pc = '0;
    logic [31:0]     lookup_instr = '0;
    logic            pred_valid;
    logic            pred_taken;
    logic [1:0]      pred_kind;
    logic            update_valid = 1'b0;
    logic [PC_W-1:0] update_pc = '0;
    logic            update_taken = 1'b0;
    logic            update_mispredict = 1'b0;
    logic [31:0]     mispredict_count;

    branch_history_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_instr(lookup_instr),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_kind(pred_kind),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_mispredict(update_mispredict), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer counters and a plain integer mispredict count
    int          m_ctr [ENTRIES];
    longint      m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        e_valid, e_taken;
    logic [1:0]  e_kind;

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > CMAX) return CMAX;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = (1 << (CTR_W - 1)) - 1;
        m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, e_valid});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e_taken});
        chk({tag, ".kind"},  {30'd0, pred_kind},  {30'd0, e_kind});
        chk({tag, ".mcnt"},  mispredict_count,    m_cnt[31:0]);
    endtask

    // One cycle: drive at negedge, predict from the model, advance model, check at next negedge
    task automatic step(input string tag, input bit lv, input logic [31:0] pc, input logic [31:0] ins,
                        input bit uv, input logic [31:0] upc, input bit ut, input bit um);
        int li, ui, c;
        lookup_valid = lv; lookup_pc = pc; lookup_instr = ins;
        update_valid = uv; update_pc = upc; update_taken = ut; update_mispredict = um;
        li = int'(pc[7:2]);
        ui = int'(upc[7:2]);
        c  = m_ctr[li];
`ifdef BHT_BYPASS_EN
        if (uv && ui == li) c = clamp(m_ctr[ui] + (ut ? 1 : -1));
`endif
        e_valid = lv; e_kind = 2'b00; e_taken = 1'b0;
        if (lv) begin
            if (ins[6:2] == 5'h18)      begin e_kind = 2'b01; e_taken = (c >= (1 << (CTR_W - 1))); end
            else if (ins[6:2] == 5'h19) begin e_kind = 2'b10; e_taken = 1'b1; end
            else if (ins[6:2] == 5'h1b) begin e_kind = 2'b11; e_taken = 1'b1; end
        end
        if (uv) begin
            m_ctr[ui] = clamp(m_ctr[ui] + (ut ? 1 : -1));
            if (um && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic rst_step(input string tag);
        reset = 1'b1;
        lookup_valid = 1'b1; lookup_pc = $urandom; lookup_instr = I_BEQ;
        update_valid = 1'b1; update_pc = $urandom; update_taken = 1'b1; update_mispredict = 1'b1;
        model_reset();
        e_valid = 1'b0; e_taken = 1'b0; e_kind = 2'b00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all(tag);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        step(tag, 1'b1, pc, ins, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input bit t, input bit m);
        step(tag, 1'b0, 32'd0, 32'd0, 1'b1, pc, t, m);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0, 1: w[6:0] = 7'h63;
            2:    w[6:0] = 7'h6F;
            3:    w[6:0] = 7'h67;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        rst_step("reset");

        look("beq_init", 32'h100, I_BEQ);
        chk("plan.beq_init_taken", {31'd0, pred_taken}, 32'd0);
        chk("plan.beq_init_kind", {30'd0, pred_kind}, 32'd1);

        upd("t1", 32'h100, 1'b1, 1'b0);
        upd("t2", 32'h100, 1'b1, 1'b0);
        look("after_2t", 32'h100, I_BEQ);
        chk("plan.after_2t_taken", {31'd0, pred_taken}, 32'd1);
        upd("t3", 32'h100, 1'b1, 1'b0);
        look("sat_hi", 32'h100, I_BEQ);
        for (int i = 0; i < 3; i++) upd("nt", 32'h100, 1'b0, 1'b0);
        look("after_3nt", 32'h100, I_BEQ);
        chk("plan.after_3nt_taken", {31'd0, pred_taken}, 32'd0);
        upd("nt4", 32'h100, 1'b0, 1'b0);
        upd("nt_probe", 32'h100, 1'b1, 1'b0);
        look("sat_lo", 32'h100, I_BEQ);
        chk("plan.sat_lo_taken", {31'd0, pred_taken}, 32'd0);

        look("jal", 32'h100, I_JAL);
        chk("plan.jal_kind", {30'd0, pred_kind}, 32'd3);
        look("jalr", 32'h100, I_JALR);
        look("add", 32'h100, I_ADD);
        step("idle", 1'b0, 32'h100, I_BEQ, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("plan.idle_valid", {31'd0, pred_valid}, 32'd0);

        upd("alias_t1", 32'h100, 1'b1, 1'b0);
        upd("alias_t2", 32'h100, 1'b1, 1'b0);
        look("alias_200", 32'h200, I_BEQ);
        chk("plan.alias_taken", {31'd0, pred_taken}, 32'd1);
        look("alias_104", 32'h104, I_BEQ);
        chk("plan.idx1_taken", {31'd0, pred_taken}, 32'd0);

        rst_step("reset2");
        step("collide", 1'b1, 32'h100, I_BEQ, 1'b1, 32'h100, 1'b1, 1'b0);
`ifdef BHT_BYPASS_EN
        chk("plan.collide_taken", {31'd0, pred_taken}, 32'd1);
`else
        chk("plan.collide_taken", {31'd0, pred_taken}, 32'd0);
`endif
        look("post_collide", 32'h100, I_BEQ);
        chk("plan.post_collide_taken", {31'd0, pred_taken}, 32'd1);

        for (int i = 0; i < 5; i++) upd("mp1", 32'h40 + 32'(i * 4), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) upd("mp0", 32'h80 + 32'(i * 4), 1'b0, 1'b0);
        step("mp_ignored", 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("plan.mcnt5", mispredict_count, 32'd5);
        rst_step("reset_mid");
        chk("plan.mcnt_reset", mispredict_count, 32'd0);
        for (int i = 0; i < ENTRIES; i++) look("init_sweep", 32'(i * 4), I_BEQ);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_step("rand_reset");
            end else begin
                step("rand",
                     ($urandom_range(0, 3) != 0),
                     {$urandom_range(0, 7), 22'd0, 6'($urandom_range(0, 7)), 2'd0}, rand_instr(),
                     ($urandom_range(0, 2) != 0),
                     {$urandom_range(0, 7), 22'd0, 6'($urandom_range(0, 7)), 2'd0},
                     1'($urandom), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_history_predictor.md
# branch_history_predictor

Parametrised conditional-branch predictor for the fetch stage. It classifies the fetched instruction as conditional branch, JALR, JAL or non-branch, and returns a registered taken/not-taken prediction. Conditional branches use a table of saturating counters indexed by PC. Execute writes resolved outcomes back into the table, and the block keeps a saturating mispredict count for performance monitoring.

## Interface
Parameters:
- ENTRIES, 64, number of counter entries; power of two, >= 2; IDX_W = $clog2(ENTRIES)
- CTR_W, 2, counter width in bits; legal 1..4
- PC_W, 32, PC width; must be >= IDX_W + 2

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous and active-high
- lookup_valid  in  1  fetch presents an instruction this cycle
- lookup_pc  in  PC_W  PC of fetched instruction
- lookup_instr  in  32  fetched instruction word
- pred_valid  out  1  registered; prediction for previous-cycle lookup
- pred_taken  out  1  registered predicted direction
- pred_kind  out  2  registered class: 00 none, 01 conditional, 10 JALR, 11 JAL
- update_valid  in  1  execute resolved a conditional branch this cycle
- update_pc  in  PC_W  PC of resolved branch
- update_taken  in  1  actual outcome
- update_mispredict  in  1  resolved outcome differed from prediction
- mispredict_count  out  32  saturating mispredict counter

## Operation
- Index: lookup_idx = lookup_pc[IDX_W+1:2]; update_idx = update_pc[IDX_W+1:2]. Upper PC bits are ignored, so aliasing is permitted.
- Decode uses lookup_instr[6:2]:
  - 5'h18 gives conditional (01).
  - 5'h19 gives JALR (10).
  - 5'h1b gives JAL (11).
  - Any other value gives none (00).
- Prediction:
  - JAL and JALR: taken 1.
  - Conditional: taken = MSB of ctr[lookup_idx].
  - None: taken 0.
- lookup_valid=0: the next cycle shows pred_valid 0, pred_taken 0, pred_kind 00.
- Update: when update_valid=1, ctr[update_idx] changes at the clock edge.
  - update_taken=1: +1, saturating at 2^CTR_W-1.
  - update_taken=0: -1, saturating at 0.
  - The block does not qualify updates by instruction class; the caller asserts update_valid only for conditional branches.
- Mispredict count: increments by 1 when update_valid && update_mispredict. It saturates at 32'hFFFF_FFFF. update_mispredict is ignored when update_valid=0.
- Reset (priority over lookup and update):
  - Every ctr entry loads weakly-not-taken, 2^(CTR_W-1)-1; for CTR_W=1 this is 0.
  - pred_valid, pred_taken, pred_kind and mispredict_count load 0.
  - All of this happens in the single reset cycle; no multi-cycle init sweep.
- Reset mid-operation: a lookup presented during a reset cycle produces no prediction; pred_valid is 0 in the cycle after reset deasserts. An update presented during reset is dropped.

## Timing
- Lookup latency is 1 cycle: inputs at edge N produce pred_* valid after edge N+1.
- The block accepts one lookup and one update per cycle, with no stall or backpressure; throughput is 1/cycle for both.
- An update is visible to lookups presented in the cycle after its edge.
- Same-cycle lookup and update to the same index: behaviour depends on BHT_BYPASS_EN (see Configuration).
- Different indices in the same cycle are fully independent.
- mispredict_count reflects an update one cycle after update_valid.

## Configuration
- BHT_BYPASS_EN defined: a same-cycle, same-index update is forwarded. The conditional prediction uses the post-update counter value.
- BHT_BYPASS_EN undefined: read-before-write. The conditional prediction uses the pre-update value, and the update is visible from the following cycle.
- The macro does not affect JAL, JALR or non-branch predictions.

## Test plan
All scenarios use ENTRIES=64, CTR_W=2.
- Reset, then lookup pc 0x100, instr 0x00000063 (BEQ) -> next cycle pred_valid 1, pred_kind 01, pred_taken 0 (counter 01).
- Two taken updates at pc 0x100 -> counter 11, lookup taken 1. A third taken update keeps 11. Three not-taken updates -> 00, lookup taken 0. A fourth keeps 00.
- Lookup instr 0x0000006F (JAL) -> kind 11, taken 1. 0x00000067 (JALR) -> kind 10, taken 1. 0x00000033 (ADD) -> kind 00, taken 0. lookup_valid=0 -> pred_valid 0, kind 00.
- Aliasing: two taken updates at pc 0x100 (index 0) -> BEQ lookup at pc 0x200 (index 0) predicts taken 1. Lookup at pc 0x104 (index 1) stays 0.
- Collision: counter 01 at index 0; same-cycle update pc 0x100 taken plus BEQ lookup pc 0x100 -> pred_taken 0 without BHT_BYPASS_EN, 1 with it. The following lookup gives 1 in both builds.
- Mispredict: 5 updates with update_mispredict=1 plus 3 with 0 -> mispredict_count 5. Assert reset for 1 cycle mid-stream -> count 0, every counter 01, pred_valid 0.
